// File: rtl/uart_pkg.sv
// +----------------------------------------------------------------------+
// | uart_pkg: shared constants and state encoding for the UART receiver  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 434;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] PARITY    = 3'd3;
  localparam logic [2:0] STOP      = 3'd4;
  localparam logic [2:0] WAIT_IDLE = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE      = IDLE,
    ST_START     = START,
    ST_DATA      = DATA,
    ST_PARITY    = PARITY,
    ST_STOP      = STOP,
    ST_WAIT_IDLE = WAIT_IDLE
  } state_t;

endpackage

`default_nettype wire

// File: rtl/uart_sync2.sv
// +----------------------------------------------------------------------+
// | uart_sync2: two-flop synchronizer for an asynchronous 1-bit input    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

`default_nettype wire

// File: rtl/uart_rx_byte.sv
// +----------------------------------------------------------------------+
// | uart_rx_byte: 8-bit UART receiver, LSB first, 8N1 or 8E1 framing.    |
// | Optional even parity via macro UART_RX_PARITY_EN.                    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] RxData,
  output logic       RxDone,
  output logic       FrameErr,
  output logic       ParityErr,
  output logic       Busy
);

  localparam logic [CNT_W-1:0] c_half = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] c_last = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       c_msb  = 3'(DATA_BITS - 1);

  logic                 w_rx_s;
  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [2:0]           r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic [7:0]           r_rx_data;
  logic                 r_rx_done;
  logic                 r_frame_err;
  logic                 r_busy;
`ifdef UART_RX_PARITY_EN
  logic                 r_par;
  logic                 r_parity_err;
`endif

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (w_rx_s)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_rx_data    <= 8'h00;
      r_rx_done    <= 1'b0;
      r_frame_err  <= 1'b0;
      r_busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par        <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_rx_done    <= 1'b0;
      r_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (!w_rx_s) begin
            r_state <= ST_START;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end

        ST_START: begin
          if (r_cnt == c_half) begin
            // A line that is high again at mid start bit was only a glitch
            if (w_rx_s) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state   <= ST_DATA;
              r_cnt     <= '0;
              r_bit_idx <= '0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_DATA: begin
          if (r_cnt == c_last) begin
            r_shift[r_bit_idx] <= w_rx_s;
            r_cnt              <= '0;
            if (r_bit_idx == c_msb) begin
`ifdef UART_RX_PARITY_EN
              r_state <= ST_PARITY;
`else
              r_state <= ST_STOP;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (r_cnt == c_last) begin
            r_par   <= w_rx_s;
            r_cnt   <= '0;
            r_state <= ST_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`endif

        ST_STOP: begin
          if (r_cnt == c_last) begin
            r_cnt <= '0;
            // Returning to IDLE at stop centre leaves half a bit to catch
            // the next start edge of a gapless stream.
            if (w_rx_s) begin
              r_rx_data <= r_shift;
              r_rx_done <= 1'b1;
`ifdef UART_RX_PARITY_EN
              r_parity_err <= ^{r_shift, r_par};
`endif
              r_state   <= ST_IDLE;
              r_busy    <= 1'b0;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= ST_WAIT_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_WAIT_IDLE: begin
          if (w_rx_s) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign RxData   = r_rx_data;
  assign RxDone   = r_rx_done;
  assign FrameErr = r_frame_err;
  assign Busy     = r_busy;
`ifdef UART_RX_PARITY_EN
  assign ParityErr = r_parity_err;
`else
  assign ParityErr = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_byte.sv
// +----------------------------------------------------------------------+
// | tb_uart_rx_byte: self-checking bench for uart_rx_byte (CLKS_PER_BIT  |
// | = 16); parity cases active when UART_RX_PARITY_EN is defined.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_uart_rx_byte;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] RxData;
  logic       RxDone;
  logic       FrameErr;
  logic       ParityErr;
  logic       Busy;

  always #5 clk = ~clk;

  uart_rx_byte #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .RxData    (RxData),
    .RxDone    (RxDone),
    .FrameErr  (FrameErr),
    .ParityErr (ParityErr),
    .Busy      (Busy)
  );

  typedef struct packed {
    logic       done;
    logic       ferr;
    logic [7:0] data;
    logic       perr;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic       exp_perr;
  } vec_t;

  exp_t       sb[$];
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         done_cyc = 0;
  logic       prev_done = 1'b0;
  logic [7:0] hist0 = 8'h00;
  logic [7:0] hist1 = 8'h00;
  logic [7:0] last_good = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every output event is matched against the oldest expectation
  always @(negedge clk) begin
    exp_t got;
    exp_t e;
    if (RxDone || FrameErr) begin
      got = '{done: RxDone, ferr: FrameErr, data: RxData, perr: ParityErr};
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event got=%h (done,ferr,data,perr) required=none", got);
      end else begin
        e = sb.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL event got=%h required=%h (done,ferr,data,perr)", got, e);
        end
      end
      if (RxDone) begin
        checks++;
        if (prev_done) begin
          errors++;
          $display("FAIL done_pulse_width got=2+ cycles required=1");
        end
        hist1    = hist0;
        hist0    = RxData;
        done_cyc = cyc;
      end
    end
    prev_done = RxDone;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h required=%h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par);
`endif
    send_bit(stop);
  endtask

  task automatic expect_byte(input logic [7:0] d, input logic perr);
    sb.push_back('{done: 1'b1, ferr: 1'b0, data: d, perr: perr});
    last_good = d;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout got=%0d pending required=0", name, sb.size());
      sb.delete();
    end
  endtask

  vec_t vecs[8];
  int   n_vec;
  int   start_cyc;

  initial begin
    vecs[0] = '{data: 8'hA5, par: ^8'hA5, stop: 1'b1, exp_perr: 1'b0};
    vecs[1] = '{data: 8'h00, par: 1'b0,   stop: 1'b1, exp_perr: 1'b0};
    vecs[2] = '{data: 8'hFF, par: 1'b0,   stop: 1'b1, exp_perr: 1'b0};
    vecs[3] = '{data: 8'h55, par: 1'b0,   stop: 1'b0, exp_perr: 1'b0};
    vecs[4] = '{data: 8'h0F, par: 1'b0,   stop: 1'b1, exp_perr: 1'b0};
    vecs[5] = '{data: 8'h81, par: 1'b0,   stop: 1'b1, exp_perr: 1'b0};
    n_vec = 6;
`ifdef UART_RX_PARITY_EN
    vecs[6] = '{data: 8'h03, par: 1'b0, stop: 1'b1, exp_perr: 1'b0};
    vecs[7] = '{data: 8'h03, par: 1'b1, stop: 1'b1, exp_perr: 1'b1};
    n_vec = 8;
`endif

    reset = 1'b1;
    rx    = 1'b1;
    repeat (4) @(negedge clk);
    chk("reset_rxdata", 32'(RxData), 32'h00);
    chk("reset_flags", {28'h0, RxDone, FrameErr, ParityErr, Busy}, 32'h0);
    reset = 1'b0;
    repeat (2 * CPB) @(negedge clk);

    // Single frame with start-edge-to-RxDone latency
    start_cyc = cyc;
    expect_byte(8'hA5, 1'b0);
    send_frame(8'hA5, ^8'hA5, 1'b1);
    wait_drain("single");
    chk("latency_ok", 32'((done_cyc - start_cyc) >= 150 + 16 * PAR_BITS &&
                          (done_cyc - start_cyc) <= 158 + 16 * PAR_BITS), 32'h1);
    chk("single_rxdata", 32'(RxData), 32'hA5);
    send_bit(1'b1);

    // Table of frames; a low stop bit is followed by 3 more low bit times
    for (int v = 0; v < n_vec; v++) begin
      if (vecs[v].stop)
        expect_byte(vecs[v].data, vecs[v].exp_perr);
      else
        sb.push_back('{done: 1'b0, ferr: 1'b1, data: last_good, perr: 1'b0});
      send_frame(vecs[v].data, vecs[v].par, vecs[v].stop);
      if (!vecs[v].stop) repeat (3) send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      wait_drain($sformatf("vec%0d", v));
      chk($sformatf("vec%0d_hold", v), 32'(RxData), 32'(last_good));
      chk($sformatf("vec%0d_idle", v), 32'(Busy), 32'h0);
    end

    // Back-to-back frames with no idle gap, assembled MSB byte first
    expect_byte(8'h12, 1'b0);
    expect_byte(8'h34, 1'b0);
    send_frame(8'h12, ^8'h12, 1'b1);
    send_frame(8'h34, ^8'h34, 1'b1);
    send_bit(1'b1);
    wait_drain("b2b");
    chk("b2b_word", 32'({hist1, hist0}), 32'h1234);

    // Short low glitch must be rejected as a false start
    rx = 1'b0;
    repeat (4) @(negedge clk);
    chk("glitch_busy_high", 32'(Busy), 32'h1);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    chk("glitch_busy_low", 32'(Busy), 32'h0);
    send_bit(1'b1);

    // Reset asserted during data bit 4 of an 8'hFF frame
    fork
      send_frame(8'hFF, 1'b0, 1'b1);
      begin
        repeat (CPB * 5 + CPB / 2) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midreset_rxdata", 32'(RxData), 32'h00);
        chk("midreset_flags", {28'h0, RxDone, FrameErr, ParityErr, Busy}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
      end
    join
    last_good = 8'h00;
    send_bit(1'b1);
    expect_byte(8'h3C, 1'b0);
    send_frame(8'h3C, ^8'h3C, 1'b1);
    send_bit(1'b1);
    wait_drain("after_reset");
    chk("after_reset_rxdata", 32'(RxData), 32'h3C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout got=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
